sha256_header_seq: RTL and testbench
====================================

# sha256_header_seq

Upstream sequencer for the `sha256` core that hashes an 80-byte block header over a sweep of nonces. The first 64-byte block is hashed once, and its midstate is cached. For each nonce, the second block is then built (the last 16 header bytes with the nonce substituted, plus SHA-256 padding) and hashed from that midstate. Each 256-bit digest is emitted with its nonce through a valid/ready handshake to the downstream consumer.

## Interface
- `CNT_W`, default 16: width of the nonce-count input.
- `clk` input, 1: system clock; all state updates on the rising edge.
- `n_rst` input, 1: asynchronous active-low reset.
- `start` input, 1: begin a job; sampled only in IDLE.
- `header` input, 640: header bytes, byte 0 in [639:632]; sampled when `start` is accepted.
- `nonce_count` input, CNT_W: number of nonces to hash; 0 is treated as 1; sampled with `header`.
- `busy` output, 1: high whenever the state is not IDLE.
- `digest` output, 256: result for `digest_nonce`.
- `digest_nonce` output, 32: nonce used for `digest`.
- `digest_valid` output, 1: `digest`/`digest_nonce` valid.
- `digest_ready` input, 1: consumer accepts when high together with `digest_valid`.
- `sha_enable` output, 1: one-cycle start pulse to the core.
- `sha_data` output, 512: message block to the core.
- `sha_current_hash` output, 256: chaining value to the core.
- `sha_hash` input, 256: core result.
- `sha_hash_done` input, 1: core completion pulse.

## Operation
- **Job capture.** On `start` in IDLE, latch:
  - `header[639:0]`;
  - nonce register ← `header[31:0]`;
  - remaining count ← max(`nonce_count`, 1).
- **IV.** 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- **Block 1.**
  - `sha_data` = `header[639:128]`.
  - `sha_current_hash` = IV.
- **Block 2.**
  - `sha_data` = {`header[127:32]`, nonce, 32'h80000000, 288'h0, 64'h0000000000000280}.
  - `sha_current_hash` = midstate register.
- **Register hold.** `sha_data` and `sha_current_hash` are driven from registers. They are held constant from the `sha_enable` cycle until `sha_hash_done`, because the core latches them one cycle after enable.
- **State machine.**
  - IDLE → MID_START on `start`.
  - MID_START: `sha_enable`=1 with block 1; → MID_WAIT.
  - MID_WAIT: wait for `sha_hash_done`; latch `sha_hash` into midstate; → BLK_START.
  - BLK_START: `sha_enable`=1 with block 2; → BLK_WAIT.
  - BLK_WAIT: wait for `sha_hash_done`; latch `sha_hash` into `digest` and the nonce into `digest_nonce`; → OUT.
  - OUT: `digest_valid`=1. On `digest_ready`:
    - decrement the count;
    - if the count was 1 → IDLE;
    - else increment the nonce mod 2^32 → BLK_START.
- **Midstate reuse.** The midstate is computed once per job and never recomputed between nonces.
- **Nonce wrap.** The nonce wraps from FFFFFFFF to 00000000 with no special handling.
- **Ignored inputs.**
  - `start` is ignored outside IDLE.
  - `header` and `nonce_count` changes after acceptance have no effect.
- **Spurious completion.** `sha_hash_done` outside MID_WAIT/BLK_WAIT is ignored.
- **Output stability.** `digest` and `digest_nonce` hold their last values after the handshake until the next BLK_WAIT capture.

## Timing
- **Reset values.**
  - State IDLE.
  - `busy`=0, `sha_enable`=0, `digest_valid`=0.
  - `digest`=0, `digest_nonce`=0, `sha_data`=0.
  - `sha_current_hash`=0; midstate, nonce and count registers 0.
- **Reset mid-job.** Reset mid-job returns to IDLE immediately. Any pending core result is discarded, and the core is reset by the same `n_rst`.
- **Enable pulse.** `sha_enable` is high for exactly one cycle per core run. It is never reasserted before `sha_hash_done`.
- **Core latency.** Core latency from the enable cycle to `sha_hash_done` is nominally 67 cycles. The block waits for `sha_hash_done` and has no fixed-latency dependency.
- **First job with `digest_ready` held high.**
  - `start` sampled at cycle 0.
  - Enable at cycle 1; done at 68.
  - Enable at 69; done at 136.
  - `digest_valid` at 137.
- **Following nonces.** Each further nonce adds 69 cycles: enable at 138, valid at 206.
- **Back-pressure.** While `digest_ready`=0 in OUT, all outputs hold and no core run starts.
- **Busy.** `busy` rises the cycle after `start` and falls the cycle after the final handshake.

## Test plan
- **Single nonce vs. software model.** Genesis-style 80-byte header with `nonce_count`=1, core model attached → exactly one `digest_valid`. `digest` equals the software SHA-256 of the 80 bytes and `digest_nonce`=`header[31:0]`; `busy` low afterwards.
- **Midstate reuse and wrap.** `nonce_count`=3, `header[31:0]`=FFFFFFFE → nonces FFFFFFFE, FFFFFFFF, 00000000 emitted in order, each digest matching the reference model. Exactly 4 `sha_enable` pulses in total; block 1 is run only once.
- **Back-pressure.** `digest_ready` low for 50 cycles in OUT → `digest` is stable and `sha_enable` stays low. Progress resumes one cycle after `digest_ready` rises.
- **Zero count.** `nonce_count`=0 → behaves as count 1: one digest.
- **Ignored start.** `start` pulsed while busy → ignored, with no change to the current job.
- **Async reset mid-job.** `n_rst` asserted during BLK_WAIT → all outputs at reset values asynchronously. A new job after release completes correctly.
- **Spurious core done.** Spurious `sha_hash_done` in OUT or IDLE → no state change and no register update.

Source files
------------

// File: rtl/sha256_header_seq.sv
// sha256_header_seq: drives a SHA-256 core over an 80-byte header, reusing the block-1 midstate for each nonce
module sha256_header_seq #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [639:0]     header,
    input  logic [CNT_W-1:0] nonce_count,
    output logic             busy,
    output logic [255:0]     digest,
    output logic [31:0]      digest_nonce,
    output logic             digest_valid,
    input  logic             digest_ready,
    output logic             sha_enable,
    output logic [511:0]     sha_data,
    output logic [255:0]     sha_current_hash,
    input  logic [255:0]     sha_hash,
    input  logic             sha_hash_done
);
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    typedef enum logic [2:0] {IDLE, MID_START, MID_WAIT, BLK_START, BLK_WAIT, OUT} state_t;

    state_t           state_q;
    logic [95:0]      tail_q;
    logic [31:0]      nonce_q;
    logic [31:0]      nonce_d;
    logic [CNT_W-1:0] cnt_q;
    logic [255:0]     mid_q;
    logic [255:0]     digest_q;
    logic [31:0]      dnonce_q;
    logic             valid_q;
    logic             en_q;
    logic [511:0]     data_q;
    logic [255:0]     chv_q;

    // second block: header tail, nonce, then padding for an 80-byte (640-bit) message
    function automatic logic [511:0] blk2(input logic [95:0] t, input logic [31:0] n);
        return {t, n, 32'h8000_0000, 288'h0, 64'h280};
    endfunction

    // next nonce wraps naturally at 2^32
    always_comb nonce_d = nonce_q + 32'd1;

    // job sequencing; core operands are registered and held from the enable cycle onwards
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IDLE;
            tail_q   <= '0;
            nonce_q  <= '0;
            cnt_q    <= '0;
            mid_q    <= '0;
            digest_q <= '0;
            dnonce_q <= '0;
            valid_q  <= 1'b0;
            en_q     <= 1'b0;
            data_q   <= '0;
            chv_q    <= '0;
        end else begin
            en_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    tail_q  <= header[127:32];
                    nonce_q <= header[31:0];
                    cnt_q   <= (nonce_count == '0) ? CNT_W'(1) : nonce_count;
                    data_q  <= header[639:128];
                    chv_q   <= IV;
                    en_q    <= 1'b1;
                    state_q <= MID_START;
                end
                MID_START: state_q <= MID_WAIT;
                MID_WAIT: if (sha_hash_done) begin
                    mid_q   <= sha_hash;
                    chv_q   <= sha_hash;
                    data_q  <= blk2(tail_q, nonce_q);
                    en_q    <= 1'b1;
                    state_q <= BLK_START;
                end
                BLK_START: state_q <= BLK_WAIT;
                BLK_WAIT: if (sha_hash_done) begin
                    digest_q <= sha_hash;
                    dnonce_q <= nonce_q;
                    valid_q  <= 1'b1;
                    state_q  <= OUT;
                end
                OUT: if (digest_ready) begin
                    valid_q <= 1'b0;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                    end else begin
                        nonce_q <= nonce_d;
                        data_q  <= blk2(tail_q, nonce_d);
                        chv_q   <= mid_q;
                        en_q    <= 1'b1;
                        state_q <= BLK_START;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = state_q != IDLE;
    assign digest           = digest_q;
    assign digest_nonce     = dnonce_q;
    assign digest_valid     = valid_q;
    assign sha_enable       = en_q;
    assign sha_data         = data_q;
    assign sha_current_hash = chv_q;
endmodule

// File: tb/tb_sha256_header_seq.sv
// tb_sha256_header_seq: checks the header sequencer against a byte-level SHA-256 reference with an attached core model
module tb_sha256_header_seq;
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [639:0] GEN = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d, 32'h1dac2b7c};
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic         clk = 1'b0;
    logic         n_rst, start, digest_ready, sha_hash_done, busy, digest_valid, sha_enable;
    logic [639:0] header;
    logic [15:0]  nonce_count;
    logic [255:0] digest, sha_current_hash, sha_hash;
    logic [31:0]  digest_nonce;
    logic [511:0] sha_data;

    sha256_header_seq #(.CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .header(header), .nonce_count(nonce_count),
        .busy(busy), .digest(digest), .digest_nonce(digest_nonce), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .sha_enable(sha_enable), .sha_data(sha_data),
        .sha_current_hash(sha_current_hash), .sha_hash(sha_hash), .sha_hash_done(sha_hash_done));

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10));
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    // plain SHA-256 of a byte message (up to 119 bytes), with standard padding
    function automatic logic [255:0] sha_msg(input logic [7:0] m [128], input int len);
        logic [7:0]   p [128];
        logic [63:0]  bl;
        logic [511:0] b;
        logic [255:0] h;
        int nb;
        nb = (len + 9 + 63) / 64;
        bl = 64'(len) * 64'd8;
        for (int i = 0; i < 128; i++) p[i] = (i < len) ? m[i] : (i == len) ? 8'h80 : 8'h00;
        for (int j = 0; j < 8; j++) p[nb*64-1-j] = bl[8*j +: 8];
        h = IV;
        for (int k = 0; k < nb; k++) begin
            for (int i = 0; i < 64; i++) b[511-8*i -: 8] = p[64*k+i];
            h = compress(h, b);
        end
        return h;
    endfunction

    function automatic logic [255:0] str_hash(input string s);
        logic [7:0] m [128];
        for (int i = 0; i < 128; i++) m[i] = (i < s.len()) ? s[i] : 8'h00;
        return sha_msg(m, s.len());
    endfunction

    // the 80 header bytes with the last four replaced by the nonce, big-endian
    function automatic logic [255:0] hdr_hash(input logic [639:0] h, input logic [31:0] n);
        logic [7:0] m [128];
        for (int i = 0; i < 128; i++) m[i] = 8'h00;
        for (int i = 0; i < 76; i++) m[i] = h[639-8*i -: 8];
        for (int i = 0; i < 4; i++) m[76+i] = n[31-8*i -: 8];
        return sha_msg(m, 80);
    endfunction

    // core model: latches operands one cycle after enable, done pulse 67 cycles after enable
    logic         core_done = 1'b0, spur = 1'b0;
    logic [255:0] core_hash = '0, spur_hash = '0;
    int           ccnt = 0;
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ccnt <= 0;
            core_done <= 1'b0;
        end else begin
            core_done <= 1'b0;
            if (ccnt > 0) begin
                ccnt <= ccnt - 1;
                if (ccnt == 66) core_hash <= compress(sha_current_hash, sha_data);
                if (ccnt == 1) core_done <= 1'b1;
            end
            if (sha_enable) ccnt <= 66;
        end
    end
    assign sha_hash_done = core_done | spur;
    assign sha_hash = spur ? spur_hash : core_hash;

    // reference state
    logic         mbusy = 1'b0, pv = 1'b0;
    logic [639:0] jh = '0;
    logic [255:0] mid = '0, last_dig = '0, expd;
    logic [31:0]  last_n = '0;
    logic [31:0]  q [$];
    int           nen_job = 0, en_total = 0, s_cyc = 0;
    int           en_rel [$], en_abs [$], vrel [$], hs_c [$];
    logic [31:0]  hs_n [$];

    // compare process: every cycle, outputs against the reference
    always @(negedge clk) begin
        if (!n_rst) begin
            chk("rst_busy", 512'(busy), 512'(0));
            chk("rst_valid", 512'(digest_valid), 512'(0));
            chk("rst_enable", 512'(sha_enable), 512'(0));
            chk("rst_digest", 512'(digest), 512'(0));
            chk("rst_nonce", 512'(digest_nonce), 512'(0));
            chk("rst_data", sha_data, 512'(0));
            chk("rst_chv", 512'(sha_current_hash), 512'(0));
            mbusy = 1'b0; pv = 1'b0; q.delete(); last_dig = '0; last_n = '0;
        end else begin
            chk("busy", 512'(busy), 512'(mbusy));
            if (digest_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL valid_unexpected: digest_valid got 1 want 0");
                end else begin
                    expd = hdr_hash(jh, q[0]);
                    chk("digest_nonce", 512'(digest_nonce), 512'(q[0]));
                    chk("digest", 512'(digest), 512'(expd));
                end
            end else begin
                chk("digest_hold", 512'(digest), 512'(last_dig));
                chk("nonce_hold", 512'(digest_nonce), 512'(last_n));
            end
            if (sha_enable) begin
                chk("enable_core_idle", 512'(ccnt), 512'(0));
                if (nen_job == 0) begin
                    chk("blk1_data", sha_data, jh[639:128]);
                    chk("blk1_chv", 512'(sha_current_hash), 512'(IV));
                end else begin
                    chk("blk2_data", sha_data, {jh[127:32], (q.size() > 0) ? q[0] : 32'hx, 32'h80000000, 288'h0, 64'h280});
                    chk("blk2_chv", 512'(sha_current_hash), 512'(mid));
                end
                nen_job++; en_total++;
                en_rel.push_back(cyc - s_cyc);
                en_abs.push_back(cyc);
            end
            if (digest_valid && !pv) vrel.push_back(cyc - s_cyc);
            pv = digest_valid;
            if (!mbusy && start) begin
                mbusy = 1'b1; jh = header; nen_job = 0; s_cyc = cyc;
                mid = compress(IV, header[639:128]);
                for (int i = 0; i < ((nonce_count == 0) ? 1 : int'(nonce_count)); i++) q.push_back(header[31:0] + 32'(i));
            end else if (digest_valid && digest_ready && q.size() > 0) begin
                last_dig = expd; last_n = q[0];
                hs_n.push_back(q[0]); hs_c.push_back(cyc);
                void'(q.pop_front());
                if (q.size() == 0) mbusy = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        en_rel.delete(); en_abs.delete(); vrel.delete(); hs_c.delete(); hs_n.delete();
    endtask

    task automatic job(input logic [639:0] h, input logic [15:0] n);
        header = h; nonce_count = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy && t < 2000) begin tick(); t++; end
        if (busy) begin total++; bad++; $display("FAIL %s_timeout: busy got 1 want 0", nm); end
    endtask

    task automatic wait_valid(input string nm);
        int t;
        t = 0;
        while (!digest_valid && t < 500) begin tick(); t++; end
        if (!digest_valid) begin total++; bad++; $display("FAIL %s_timeout: digest_valid got 0 want 1", nm); end
    endtask

    logic [255:0] d0;
    int           e0;

    initial begin
        n_rst = 1'b0; start = 1'b0; digest_ready = 1'b1; header = '0; nonce_count = '0;
        tick(3);
        n_rst = 1'b1;
        tick(2);
        chk("model_abc", 512'(str_hash("abc")),
            512'(256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad));
        chk("model_2blk", 512'(str_hash("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq")),
            512'(256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1));

        // single nonce on the genesis-style header
        clear_log();
        job(GEN, 16'd1);
        wait_idle("genesis");
        chk("gen_handshakes", 512'(hs_n.size()), 512'(1));
        chk("gen_nonce", 512'((hs_n.size() > 0) ? hs_n[0] : 32'h0), 512'(32'h1dac2b7c));
        chk("gen_valid_cycle", 512'((vrel.size() > 0) ? vrel[0] : -1), 512'(137));
        chk("gen_en1_cycle", 512'((en_rel.size() > 0) ? en_rel[0] : -1), 512'(1));
        chk("gen_en2_cycle", 512'((en_rel.size() > 1) ? en_rel[1] : -1), 512'(69));
        chk("gen_busy_after", 512'(busy), 512'(0));

        // three nonces across the 2^32 wrap, midstate reused
        clear_log();
        job({GEN[639:32], 32'hFFFFFFFE}, 16'd3);
        wait_idle("wrap");
        chk("wrap_enables", 512'(en_rel.size()), 512'(4));
        chk("wrap_en3_cycle", 512'((en_rel.size() > 2) ? en_rel[2] : -1), 512'(138));
        chk("wrap_en4_cycle", 512'((en_rel.size() > 3) ? en_rel[3] : -1), 512'(207));
        chk("wrap_valid2_cycle", 512'((vrel.size() > 1) ? vrel[1] : -1), 512'(206));
        chk("wrap_valid3_cycle", 512'((vrel.size() > 2) ? vrel[2] : -1), 512'(275));
        chk("wrap_n0", 512'((hs_n.size() > 0) ? hs_n[0] : 32'h1), 512'(32'hFFFFFFFE));
        chk("wrap_n1", 512'((hs_n.size() > 1) ? hs_n[1] : 32'h1), 512'(32'hFFFFFFFF));
        chk("wrap_n2", 512'((hs_n.size() > 2) ? hs_n[2] : 32'h1), 512'(32'h00000000));

        // back-pressure with a spurious done while waiting in OUT
        clear_log();
        digest_ready = 1'b0;
        job({GEN[639:32], 32'h12345678}, 16'd2);
        wait_valid("bp");
        d0 = digest; e0 = en_total;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin spur_hash = {8{$urandom}}; spur = 1'b1; end
            if (i == 11) spur = 1'b0;
            tick();
        end
        chk("bp_digest_stable", 512'(digest), 512'(d0));
        chk("bp_no_enable", 512'(en_total), 512'(e0));
        chk("bp_still_valid", 512'(digest_valid), 512'(1));
        digest_ready = 1'b1;
        wait_idle("bp");
        chk("bp_resume", 512'((en_abs.size() > 2) ? en_abs[2] : -1), 512'((hs_c.size() > 0) ? hs_c[0] + 1 : -2));
        chk("bp_handshakes", 512'(hs_n.size()), 512'(2));

        // zero count behaves as one
        clear_log();
        job({GEN[639:32], 32'h0000ABCD}, 16'd0);
        wait_idle("zero");
        chk("zero_handshakes", 512'(hs_n.size()), 512'(1));
        chk("zero_nonce", 512'((hs_n.size() > 0) ? hs_n[0] : 32'h0), 512'(32'h0000ABCD));

        // start while busy is ignored, as are later header/count changes
        clear_log();
        job({GEN[639:32], 32'h00000100}, 16'd2);
        tick(20);
        header = {$urandom, $urandom, GEN[575:0]}; nonce_count = 16'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ign");
        chk("ign_handshakes", 512'(hs_n.size()), 512'(2));
        chk("ign_n1", 512'((hs_n.size() > 1) ? hs_n[1] : 32'h0), 512'(32'h00000101));

        // spurious done in IDLE
        spur_hash = {8{$urandom}}; spur = 1'b1;
        tick();
        spur = 1'b0;
        tick(2);
        chk("idle_spur_busy", 512'(busy), 512'(0));
        chk("idle_spur_digest", 512'(digest), 512'(last_dig));

        // asynchronous reset during BLK_WAIT, then a clean job
        clear_log();
        e0 = en_total;
        job({GEN[639:32], 32'h00C0FFEE}, 16'd2);
        for (int i = 0; i < 300 && en_total < e0 + 2; i++) tick();
        chk("rst_reached_blk", 512'(en_total), 512'(e0 + 2));
        tick(10);
        #2 n_rst = 1'b0;
        #1;
        chk("async_busy", 512'(busy), 512'(0));
        chk("async_valid", 512'(digest_valid), 512'(0));
        chk("async_data", sha_data, 512'(0));
        chk("async_chv", 512'(sha_current_hash), 512'(0));
        tick(2);
        n_rst = 1'b1;
        tick(2);
        clear_log();
        job({GEN[639:32], 32'h00000042}, 16'd1);
        wait_idle("post_rst");
        chk("post_rst_handshakes", 512'(hs_n.size()), 512'(1));
        chk("post_rst_nonce", 512'((hs_n.size() > 0) ? hs_n[0] : 32'h0), 512'(32'h00000042));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
